// File: rtl/reorder_buffer_pkg.sv
// Shared core definitions: register-file sizes, ROB depth and the ROB entry layout.
package reorder_buffer_pkg;

    localparam int NUM_D_REG  = 64;
    localparam int NUM_S_REG  = 16;
    localparam int ROB_DEPTH  = 16;
    localparam int D_ADDR_W_P = $clog2(NUM_D_REG);
    localparam int S_ADDR_W_P = $clog2(NUM_S_REG);

    typedef struct packed {
        logic                  busy;
        logic                  done;
        logic                  write_rw;
        logic [D_ADDR_W_P-1:0] prev_rw_addr;
        logic                  write_rs;
        logic [S_ADDR_W_P-1:0] prev_rs_addr;
    } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement queue: allocates at tail, marks completion from two
// writeback paths, retires the oldest completed entry once per cycle.
module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int DEPTH    = ROB_DEPTH,
    parameter int D_ADDR_W = D_ADDR_W_P,
    parameter int S_ADDR_W = S_ADDR_W_P,
    localparam int TW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                alloc_valid,
    output logic                alloc_ready,
    output logic [TW-1:0]       alloc_tag,
    input  logic                alloc_write_rw,
    input  logic                alloc_write_rs,
    input  logic [D_ADDR_W-1:0] alloc_prev_rw_addr,
    input  logic [S_ADDR_W-1:0] alloc_prev_rs_addr,
    input  logic                cmp_a_valid,
    input  logic [TW-1:0]       cmp_a_tag,
    input  logic                cmp_c_valid,
    input  logic [TW-1:0]       cmp_c_tag,
    output logic                rob_out_valid,
    output logic                rob_out_write_rw,
    output logic                rob_out_write_rs,
    output logic [D_ADDR_W-1:0] rob_out_prev_rw_addr,
    output logic [S_ADDR_W-1:0] rob_out_prev_rs_addr,
    output logic [TW:0]         count,
    output logic                empty,
    output logic                full
);

    rob_entry_t    r_ent [DEPTH];
    logic [TW-1:0] r_head;
    logic [TW-1:0] r_tail;
    logic [TW:0]   r_count;

    logic w_full;
    logic w_alloc;
    logic w_retire;

    assign w_full   = (r_count == (TW+1)'(DEPTH));
    assign w_alloc  = alloc_valid && !w_full;
    assign w_retire = r_ent[r_head].busy && r_ent[r_head].done;

    assign alloc_ready = !w_full;
    assign alloc_tag   = r_tail;
    assign full        = w_full;
    assign empty       = (r_count == '0);
    assign count       = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i] <= '0;
            end
            r_head               <= '0;
            r_tail               <= '0;
            r_count              <= '0;
            rob_out_valid        <= 1'b0;
            rob_out_write_rw     <= 1'b0;
            rob_out_write_rs     <= 1'b0;
            rob_out_prev_rw_addr <= '0;
            rob_out_prev_rs_addr <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_ent[i].busy <= 1'b0;
                r_ent[i].done <= 1'b0;
            end
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            rob_out_valid <= 1'b0;
        end else begin
            // Completions to idle slots are dropped; a dual hit is one set.
            for (int i = 0; i < DEPTH; i++) begin
                if (r_ent[i].busy &&
                    ((cmp_a_valid && cmp_a_tag == TW'(i)) ||
                     (cmp_c_valid && cmp_c_tag == TW'(i)))) begin
                    r_ent[i].done <= 1'b1;
                end
            end
            if (w_retire) begin
                r_ent[r_head].busy   <= 1'b0;
                r_head               <= r_head + 1'b1;
                rob_out_valid        <= 1'b1;
                rob_out_write_rw     <= r_ent[r_head].write_rw;
                rob_out_write_rs     <= r_ent[r_head].write_rs;
                rob_out_prev_rw_addr <= r_ent[r_head].prev_rw_addr;
                rob_out_prev_rs_addr <= r_ent[r_head].prev_rs_addr;
            end else begin
                rob_out_valid <= 1'b0;
            end
            if (w_alloc) begin
                r_ent[r_tail] <= '{busy:         1'b1,
                                   done:         1'b0,
                                   write_rw:     alloc_write_rw,
                                   prev_rw_addr: alloc_prev_rw_addr,
                                   write_rs:     alloc_write_rs,
                                   prev_rs_addr: alloc_prev_rs_addr};
                r_tail <= r_tail + 1'b1;
            end
            r_count <= r_count + (TW+1)'(w_alloc) - (TW+1)'(w_retire);
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: queue-based reference model, directed scenarios
// with literal expectations, then randomized traffic.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic       alloc_valid = 1'b0;
    logic       alloc_ready;
    logic [3:0] alloc_tag;
    logic       alloc_write_rw = 1'b0;
    logic       alloc_write_rs = 1'b0;
    logic [5:0] alloc_prev_rw_addr = '0;
    logic [3:0] alloc_prev_rs_addr = '0;
    logic       cmp_a_valid = 1'b0;
    logic [3:0] cmp_a_tag = '0;
    logic       cmp_c_valid = 1'b0;
    logic [3:0] cmp_c_tag = '0;
    logic       rob_out_valid;
    logic       rob_out_write_rw;
    logic       rob_out_write_rs;
    logic [5:0] rob_out_prev_rw_addr;
    logic [3:0] rob_out_prev_rs_addr;
    logic [4:0] count;
    logic       empty;
    logic       full;

    reorder_buffer dut (
        .clk                  (clk),
        .rst                  (rst),
        .flush                (flush),
        .alloc_valid          (alloc_valid),
        .alloc_ready          (alloc_ready),
        .alloc_tag            (alloc_tag),
        .alloc_write_rw       (alloc_write_rw),
        .alloc_write_rs       (alloc_write_rs),
        .alloc_prev_rw_addr   (alloc_prev_rw_addr),
        .alloc_prev_rs_addr   (alloc_prev_rs_addr),
        .cmp_a_valid          (cmp_a_valid),
        .cmp_a_tag            (cmp_a_tag),
        .cmp_c_valid          (cmp_c_valid),
        .cmp_c_tag            (cmp_c_tag),
        .rob_out_valid        (rob_out_valid),
        .rob_out_write_rw     (rob_out_write_rw),
        .rob_out_write_rs     (rob_out_write_rs),
        .rob_out_prev_rw_addr (rob_out_prev_rw_addr),
        .rob_out_prev_rs_addr (rob_out_prev_rs_addr),
        .count                (count),
        .empty                (empty),
        .full                 (full)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of in-flight instructions.
    typedef struct {
        int tag;
        bit done;
        bit wrw;
        bit wrs;
        int prw;
        int prs;
    } ment_t;

    ment_t q[$];
    int    m_tail;
    bit    m_vld;
    bit    m_wrw;
    bit    m_wrs;
    int    m_prw;
    int    m_prs;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_tail = 0;
        m_vld = 0;
        m_wrw = 0;
        m_wrs = 0;
        m_prw = 0;
        m_prs = 0;
    endtask

    task automatic model_step();
        bit    ret;
        bit    acc;
        ment_t e;
        if (rst) begin
            model_reset();
            return;
        end
        if (flush) begin
            q.delete();
            m_tail = 0;
            m_vld = 0;
            return;
        end
        ret = (q.size() > 0) && q[0].done;
        acc = alloc_valid && (q.size() < DEPTH);
        m_vld = ret;
        if (ret) begin
            e = q.pop_front();
            m_wrw = e.wrw;
            m_wrs = e.wrs;
            m_prw = e.prw;
            m_prs = e.prs;
        end
        foreach (q[i]) begin
            if ((cmp_a_valid && q[i].tag == int'(cmp_a_tag)) ||
                (cmp_c_valid && q[i].tag == int'(cmp_c_tag)))
                q[i].done = 1;
        end
        if (acc) begin
            e.tag = m_tail;
            e.done = 0;
            e.wrw = alloc_write_rw;
            e.wrs = alloc_write_rs;
            e.prw = int'(alloc_prev_rw_addr);
            e.prs = int'(alloc_prev_rs_addr);
            q.push_back(e);
            m_tail = (m_tail + 1) % DEPTH;
        end
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            #2;
            chk("count", int'(count), q.size());
            chk("empty", int'(empty), int'(q.size() == 0));
            chk("full", int'(full), int'(q.size() == DEPTH));
            chk("alloc_ready", int'(alloc_ready), int'(q.size() < DEPTH));
            chk("alloc_tag", int'(alloc_tag), m_tail);
            chk("rob_out_valid", int'(rob_out_valid), int'(m_vld));
            chk("rob_out_write_rw", int'(rob_out_write_rw), int'(m_wrw));
            chk("rob_out_write_rs", int'(rob_out_write_rs), int'(m_wrs));
            chk("rob_out_prev_rw", int'(rob_out_prev_rw_addr), m_prw);
            chk("rob_out_prev_rs", int'(rob_out_prev_rs_addr), m_prs);
        end
    end

    task automatic idle_inputs();
        flush = 0;
        alloc_valid = 0;
        cmp_a_valid = 0;
        cmp_c_valid = 0;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic do_reset();
        rst = 1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        idle_inputs();
    endtask

    task automatic alloc(input int prw, input int prs, input bit wrw, input bit wrs);
        alloc_valid = 1;
        alloc_prev_rw_addr = 6'(prw);
        alloc_prev_rs_addr = 4'(prs);
        alloc_write_rw = wrw;
        alloc_write_rs = wrs;
    endtask

    task automatic cmp_a(input int t);
        cmp_a_valid = 1;
        cmp_a_tag = 4'(t);
    endtask

    task automatic cmp_c(input int t);
        cmp_c_valid = 1;
        cmp_c_tag = 4'(t);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        chk_en = 1;
        chk("reset_count", int'(count), 0);
        chk("reset_empty", int'(empty), 1);
        chk("reset_alloc_tag", int'(alloc_tag), 0);
        chk("reset_ready", int'(alloc_ready), 1);

        // In-order completion: three beats 5,6,7
        alloc(5, 1, 1, 0); tick();
        alloc(6, 2, 1, 1); tick();
        alloc(7, 3, 0, 1); tick();
        chk("three_count", int'(count), 3);
        cmp_a(0); cmp_c(1); tick();
        chk("no_beat_yet", int'(rob_out_valid), 0);
        cmp_a(2); tick();
        chk("beat0_valid", int'(rob_out_valid), 1);
        chk("beat0_prw", int'(rob_out_prev_rw_addr), 5);
        tick();
        chk("beat1_prw", int'(rob_out_prev_rw_addr), 6);
        chk("beat1_wrs", int'(rob_out_write_rs), 1);
        tick();
        chk("beat2_prw", int'(rob_out_prev_rw_addr), 7);
        tick();
        chk("beats_done", int'(rob_out_valid), 0);
        chk("beats_empty", int'(empty), 1);

        // Out-of-order completion: tags 3,4,5
        alloc(10, 4, 1, 0); tick();
        alloc(11, 5, 1, 0); tick();
        alloc(12, 6, 1, 0); tick();
        cmp_a(5); tick();
        cmp_c(4); tick();
        chk("ooo_wait", int'(rob_out_valid), 0);
        cmp_a(3); tick();
        chk("ooo_same_edge", int'(rob_out_valid), 0);
        tick();
        chk("ooo_r3", int'(rob_out_prev_rw_addr), 10);
        tick();
        chk("ooo_r4", int'(rob_out_prev_rw_addr), 11);
        tick();
        chk("ooo_r5", int'(rob_out_prev_rw_addr), 12);
        chk("ooo_r5_valid", int'(rob_out_valid), 1);

        // Fill and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            alloc(20 + i, i, 1, 1); tick();
        end
        chk("fill_full", int'(full), 1);
        chk("fill_ready", int'(alloc_ready), 0);
        chk("fill_count", int'(count), 16);
        alloc(50, 9, 1, 0); cmp_a(0); tick();
        chk("fill_hold", int'(count), 16);
        alloc(50, 9, 1, 0); tick();
        chk("wrap_count", int'(count), 15);
        chk("wrap_tag", int'(alloc_tag), 0);
        alloc(50, 9, 1, 0); tick();
        chk("wrap_accept", int'(count), 16);
        chk("wrap_tag_next", int'(alloc_tag), 1);

        // Dual completion on one tag, completion on idle tag
        do_reset();
        alloc(30, 1, 1, 0); tick();
        alloc(31, 2, 1, 0); tick();
        cmp_a(0); cmp_c(0); tick();
        cmp_a(5); cmp_c(5); tick();
        chk("dual_beat", int'(rob_out_valid), 1);
        chk("dual_prw", int'(rob_out_prev_rw_addr), 30);
        tick();
        chk("dual_single", int'(rob_out_valid), 0);
        chk("dual_count", int'(count), 1);

        // Flush beats alloc, completion and a retireable head
        cmp_a(1); tick();
        flush = 1; alloc(40, 3, 1, 1); cmp_a(2); tick();
        chk("flush_count", int'(count), 0);
        chk("flush_empty", int'(empty), 1);
        chk("flush_valid", int'(rob_out_valid), 0);
        chk("flush_tag", int'(alloc_tag), 0);

        // Asynchronous reset mid-stream
        alloc(41, 3, 1, 1); tick();
        alloc(42, 4, 1, 1); tick();
        cmp_a(0); tick();
        tick();
        chk("pre_rst_valid", int'(rob_out_valid), 1);
        #1 rst = 1;
        model_reset();
        #1;
        chk("arst_valid", int'(rob_out_valid), 0);
        chk("arst_count", int'(count), 0);
        chk("arst_empty", int'(empty), 1);
        chk("arst_prw", int'(rob_out_prev_rw_addr), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            int cand[$];
            foreach (q[i]) if (!q[i].done) cand.push_back(q[i].tag);
            if ($urandom_range(0, 99) < 70)
                alloc($urandom_range(0, 63), $urandom_range(0, 15),
                      1'($urandom), 1'($urandom));
            if ($urandom_range(0, 99) < 60) begin
                if (cand.size() > 0 && $urandom_range(0, 3) != 0)
                    cmp_a(cand[$urandom_range(0, cand.size() - 1)]);
                else
                    cmp_a($urandom_range(0, 15));
            end
            if ($urandom_range(0, 99) < 50) begin
                if (cmp_a_valid && $urandom_range(0, 5) == 0)
                    cmp_c(int'(cmp_a_tag));
                else if (cand.size() > 0)
                    cmp_c(cand[$urandom_range(0, cand.size() - 1)]);
                else
                    cmp_c($urandom_range(0, 15));
            end
            if ($urandom_range(0, 299) == 0)
                flush = 1;
            tick();
        end

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
